// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, slot state, defaults.
// Imported by alu_arbiter and rr_arbiter.
package alu_arbiter_pkg;

   localparam int DATA_WIDTH_DEF    = 32;
   localparam int OPCODE_LENGTH_DEF = 4;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_XOR  = 4'b0010;
   localparam logic [3:0] ALU_ADD  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_BEQ  = 4'b1000;
   localparam logic [3:0] ALU_BNE  = 4'b1001;
   localparam logic [3:0] ALU_SLT  = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1011;
   localparam logic [3:0] ALU_BLT  = 4'b1100;
   localparam logic [3:0] ALU_BGE  = 4'b1101;
   localparam logic [3:0] ALU_BLTU = 4'b1110;
   localparam logic [3:0] ALU_BGEU = 4'b1111;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: searches req upward from ptr with wrap-around.
// Ports: req, ptr in; one-hot gnt, its index gnt_id and any-grant flag out.
module rr_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_id,
   output logic          any
);

   int idx;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      idx    = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with a 1-deep
// registered response slot. Ports: req_* (valid/ready/operands/op) in,
// alu_* to/from the shared ALU, rsp_* (valid/ready/data/id) out.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int OPCODE_LENGTH = OPCODE_LENGTH_DEF,
   parameter int NUM_REQ       = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
   input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
   output logic [DATA_WIDTH-1:0]            alu_srca,
   output logic [DATA_WIDTH-1:0]            alu_srcb,
   output logic [OPCODE_LENGTH-1:0]         alu_op,
   input  logic [DATA_WIDTH-1:0]            alu_result,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   output logic [$clog2(NUM_REQ)-1:0]       rsp_id
);

   localparam int IW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
      $error("alu_arbiter: NUM_REQ must be 2..4");
   end

   slot_state_t        state;
   slot_state_t        state_nxt;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      gnt_id;
   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] req_m;
   logic               slot_free;
   logic               any;

   // rst_n gates the slot so no request is accepted while in reset.
   assign slot_free = rst_n & ((state == EMPTY) | rsp_ready);
   assign req_m     = req_valid & {NUM_REQ{slot_free}};

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_arb (
      .req    (req_m),
      .ptr    (rr_ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .any    (any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data <= '0;
         rsp_id   <= '0;
         rr_ptr   <= '0;
      end else if (any) begin
         rsp_data <= alu_result;
         rsp_id   <= gnt_id;
         rr_ptr   <= IW'((int'(gnt_id) + 1) % NUM_REQ);
      end
   end

   // A grant always (re)fills; a free slot without grant drains.
   always_comb begin
      state_nxt = state;
      if (any) begin
         state_nxt = FULL;
      end else if (slot_free) begin
         state_nxt = EMPTY;
      end
   end

   always_comb begin
      req_ready = gnt;
      rsp_valid = (state == FULL);
      alu_srca  = '0;
      alu_srcb  = '0;
      alu_op    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            alu_srca = req_srca[i*DATA_WIDTH +: DATA_WIDTH];
            alu_srcb = req_srcb[i*DATA_WIDTH +: DATA_WIDTH];
            alu_op   = req_op[i*OPCODE_LENGTH +: OPCODE_LENGTH];
         end
      end
   end

endmodule
